// File: rtl/bist_signature_analyzer_if.sv
// Controller-facing bundle of the BIST signature analyzer: control strobes and CUT
// response in, signature and verdict out.
interface bist_signature_analyzer_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 12
);
    logic             init;
    logic             running;
    logic             finish;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] signature;
    logic [CW-1:0]    cycle_count;
    logic             result_valid;
    logic             pass_fail;

    // The master is the BIST controller/top level; the slave is the analyzer.
    modport master (
        output init, running, finish, data_in,
        input  signature, cycle_count, result_valid, pass_fail
    );

    modport slave (
        input  init, running, finish, data_in,
        output signature, cycle_count, result_valid, pass_fail
    );
endinterface

// File: rtl/bist_signature_analyzer.sv
// BIST response compactor: folds the CUT response into a Galois MISR while running,
// then compares signature and compaction count against golden values on finish.
module bist_signature_analyzer #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h002D,
    parameter logic [WIDTH-1:0] SEED       = 16'hFFFF,
    parameter logic [WIDTH-1:0] GOLDEN     = 16'h0000,
    parameter int               EXP_CYCLES = 651,
    parameter int               CW         = $clog2(EXP_CYCLES) + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    bist_signature_analyzer_if.slave   bus
);

    localparam logic [CW-1:0] EXP_C = CW'(EXP_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COMPACT = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             valid_q;
    logic             pass_q;
    logic             verdict_d;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

    // Saturating so that an overrun can never alias back onto EXP_CYCLES.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign sig_d     = misr_step(sig_q, bus.data_in);
    assign cnt_d     = sat_inc(cnt_q);
    assign verdict_d = (sig_q == GOLDEN) && (cnt_q == EXP_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
        end else if (bus.init) begin
            state_q <= ARMED;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // finish without an init is an aborted test: report fail.
                    if (bus.finish) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        pass_q  <= 1'b0;
                    end
                end
                ARMED, COMPACT: begin
                    if (bus.finish) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        pass_q  <= verdict_d;
                    end else if (bus.running) begin
                        state_q <= COMPACT;
                        sig_q   <= sig_d;
                        cnt_q   <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.signature    = sig_q;
    assign bus.cycle_count  = cnt_q;
    assign bus.result_valid = valid_q;
    assign bus.pass_fail    = pass_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Bench for bist_signature_analyzer: a small 4-bit instance for hand-computed vectors and
// a default 16-bit instance for the full-length controller-style run.
module tb_bist_signature_analyzer;

    localparam logic [15:0] GOLDEN_L = 16'hC0DE;

    typedef struct {
        logic [15:0] sig;
        int          cnt;
        logic        pass;
        int          fcyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t qs[$];
    exp_t ql[$];
    logic prev_s = 1'b0;
    logic prev_l = 1'b0;

    bist_signature_analyzer_if #(.WIDTH(4),  .CW(4))  bs ();
    bist_signature_analyzer_if #(.WIDTH(16), .CW(12)) bl ();

    bist_signature_analyzer #(
        .WIDTH(4), .POLY(4'h3), .SEED(4'h1), .GOLDEN(4'h8), .EXP_CYCLES(3)
    ) dut_s (
        .clk(clk), .reset(reset), .bus(bs.slave)
    );

    bist_signature_analyzer #(
        .GOLDEN(GOLDEN_L)
    ) dut_l (
        .clk(clk), .reset(reset), .bus(bl.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] misr16(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ d;
    endfunction

    task automatic s_drive(input logic i, input logic r, input logic f, input logic [3:0] d);
        bs.init = i; bs.running = r; bs.finish = f; bs.data_in = d;
        @(posedge clk); #1;
    endtask

    task automatic l_drive(input logic i, input logic r, input logic f, input logic [15:0] d);
        bl.init = i; bl.running = r; bl.finish = f; bl.data_in = d;
        @(posedge clk); #1;
    endtask

    task automatic push_s(input logic [3:0] sig, input int cnt, input logic pass);
        exp_t e;
        e.sig = {12'h000, sig}; e.cnt = cnt; e.pass = pass; e.fcyc = cyc;
        qs.push_back(e);
    endtask

    task automatic push_l(input logic [15:0] sig, input int cnt, input logic pass);
        exp_t e;
        e.sig = sig; e.cnt = cnt; e.pass = pass; e.fcyc = cyc;
        ql.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bs.result_valid && !prev_s) begin
                if (qs.size() == 0) begin
                    check("s_unexpected_verdict", 32'd1, 32'd0);
                end else begin
                    e = qs.pop_front();
                    check("s_verdict_sig",  {28'h0, bs.signature}, e.sig);
                    check("s_verdict_cnt",  {28'h0, bs.cycle_count}, e.cnt);
                    check("s_verdict_pass", {31'h0, bs.pass_fail}, {31'h0, e.pass});
                    check("s_verdict_latency", cyc, e.fcyc + 1);
                end
            end
            if (bl.result_valid && !prev_l) begin
                if (ql.size() == 0) begin
                    check("l_unexpected_verdict", 32'd1, 32'd0);
                end else begin
                    e = ql.pop_front();
                    check("l_verdict_sig",  {16'h0, bl.signature}, e.sig);
                    check("l_verdict_cnt",  {20'h0, bl.cycle_count}, e.cnt);
                    check("l_verdict_pass", {31'h0, bl.pass_fail}, {31'h0, e.pass});
                    check("l_verdict_latency", cyc, e.fcyc + 1);
                end
            end
            prev_s = bs.result_valid;
            prev_l = bl.result_valid;
        end
    endtask

    task automatic stimulus();
        logic [3:0]  seq3 [3];
        logic [15:0] m;
        logic [15:0] d;
        int          stable;

        reset = 1'b1;
        bs.init = 0; bs.running = 0; bs.finish = 0; bs.data_in = '0;
        bl.init = 0; bl.running = 0; bl.finish = 0; bl.data_in = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_s_sig",   {28'h0, bs.signature}, 32'h1);
        check("rst_s_cnt",   {28'h0, bs.cycle_count}, 32'h0);
        check("rst_s_valid", {31'h0, bs.result_valid}, 32'h0);
        check("rst_s_pass",  {31'h0, bs.pass_fail}, 32'h0);
        check("rst_l_sig",   {16'h0, bl.signature}, 32'hFFFF);
        check("rst_l_valid", {31'h0, bl.result_valid}, 32'h0);
        reset = 1'b0;

        // finish with no init: abort verdict
        push_s(4'h1, 0, 1'b0);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);
        s_drive(0, 1, 0, 4'hF);
        s_drive(0, 1, 0, 4'hF);
        check("done_run_ignored_sig", {28'h0, bs.signature}, 32'h1);
        check("done_run_ignored_cnt", {28'h0, bs.cycle_count}, 32'h0);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);
        check("done_finish_ignored_valid", {31'h0, bs.result_valid}, 32'h1);

        // nominal pass: 1 -> 2 -> 4 -> 8
        s_drive(1, 0, 0, 4'h0);
        check("init_sig",   {28'h0, bs.signature}, 32'h1);
        check("init_cnt",   {28'h0, bs.cycle_count}, 32'h0);
        check("init_valid", {31'h0, bs.result_valid}, 32'h0);
        seq3[0] = 4'h2; seq3[1] = 4'h4; seq3[2] = 4'h8;
        for (int k = 0; k < 3; k++) begin
            s_drive(0, 1, 0, 4'h0);
            check("pass_seq_sig", {28'h0, bs.signature}, {28'h0, seq3[k]});
            check("pass_seq_cnt", {28'h0, bs.cycle_count}, k + 1);
        end
        push_s(4'h8, 3, 1'b1);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);

        // four compactions with one hold cycle in the middle: overrun fails
        s_drive(1, 0, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 0, 0, 4'hF);
        check("hold_sig", {28'h0, bs.signature}, 32'h4);
        check("hold_cnt", {28'h0, bs.cycle_count}, 32'h2);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        push_s(4'h3, 4, 1'b0);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);

        // corrupted response: 1 -> 2 -> 5 -> A
        s_drive(1, 0, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 1, 0, 4'h1);
        s_drive(0, 1, 0, 4'h0);
        check("corrupt_sig", {28'h0, bs.signature}, 32'hA);
        push_s(4'hA, 3, 1'b0);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);

        // counter saturation at 15; x^4+x+1 has period 15, so 20 steps land on state 6
        s_drive(1, 0, 0, 4'h0);
        for (int k = 0; k < 20; k++) s_drive(0, 1, 0, 4'h0);
        check("sat_cnt", {28'h0, bs.cycle_count}, 32'hF);
        check("sat_sig", {28'h0, bs.signature}, 32'h6);
        push_s(4'h6, 15, 1'b0);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);

        // init + finish together mid-compaction: re-armed, no verdict
        s_drive(1, 0, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(1, 1, 1, 4'h0);
        check("initfin_sig",   {28'h0, bs.signature}, 32'h1);
        check("initfin_cnt",   {28'h0, bs.cycle_count}, 32'h0);
        check("initfin_valid", {31'h0, bs.result_valid}, 32'h0);
        for (int k = 0; k < 3; k++) s_drive(0, 1, 0, 4'h0);
        push_s(4'h8, 3, 1'b1);
        s_drive(0, 0, 1, 4'h0);
        s_drive(0, 0, 0, 4'h0);

        // asynchronous reset mid-compaction, between clock edges
        s_drive(1, 0, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        s_drive(0, 1, 0, 4'h0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sig",   {28'h0, bs.signature}, 32'h1);
        check("async_rst_cnt",   {28'h0, bs.cycle_count}, 32'h0);
        check("async_rst_valid", {31'h0, bs.result_valid}, 32'h0);
        check("async_rst_pass",  {31'h0, bs.pass_fail}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bs.running = 1'b0;
        s_drive(0, 0, 0, 4'h0);

        // full-length run on the default instance: 651 compactions, golden reached
        l_drive(1, 0, 0, 16'h0);
        m = 16'hFFFF;
        for (int i = 0; i < 651; i++) begin
            if (i == 300) begin
                l_drive(0, 0, 0, 16'hFFFF);
                check("l_hold_sig", {16'h0, bl.signature}, {16'h0, m});
                check("l_hold_cnt", {20'h0, bl.cycle_count}, 32'd300);
            end
            if (i == 650) d = misr16(m, 16'h0000) ^ GOLDEN_L;
            else          d = 16'(i * 40503) ^ 16'h5A5A;
            m = misr16(m, d);
            l_drive(0, 1, 0, d);
        end
        check("l_final_sig", {16'h0, bl.signature}, {16'h0, GOLDEN_L});
        check("l_final_cnt", {20'h0, bl.cycle_count}, 32'd651);
        push_l(GOLDEN_L, 651, 1'b1);
        l_drive(0, 0, 1, 16'h0);
        stable = 0;
        for (int i = 0; i < 100; i++) begin
            l_drive(0, i[0], 0, 16'(i * 7));
            if (bl.result_valid === 1'b1 && bl.pass_fail === 1'b1 &&
                bl.signature === GOLDEN_L && bl.cycle_count === 12'd651)
                stable++;
        end
        check("l_verdict_stable_cycles", stable, 100);
        l_drive(1, 0, 0, 16'h0);
        check("l_reinit_valid", {31'h0, bl.result_valid}, 32'h0);
        check("l_reinit_sig",   {16'h0, bl.signature}, 32'hFFFF);
        l_drive(0, 0, 0, 16'h0);

        @(posedge clk); @(posedge clk); #1;
        check("s_queue_drained", qs.size(), 0);
        check("l_queue_drained", ql.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bist_signature_analyzer.md
Name: bist_signature_analyzer

Overview:
Response-compaction and verdict stage of the BIST loop. It sits directly downstream of the BIST controller and consumes its init/running/finish strobes. While running is high, it folds the circuit-under-test response into a multiple-input signature register (MISR). On finish it compares the signature and the compaction-cycle count against golden values and drives a sticky pass_fail verdict back up to the top level.

Parameters:
WIDTH, 16, width of data_in and of the MISR.
POLY, 16'h002D, Galois feedback taps (x^16+x^5+x^3+x^2+1); bit i set means XOR feedback into bit i.
SEED, 16'hFFFF, MISR value loaded on init.
GOLDEN, 16'h0000, expected final signature; set per-design from golden simulation.
EXP_CYCLES, 651, expected number of compaction cycles (controller NCLOCK+1).
CW, $clog2(EXP_CYCLES)+2, width of the compaction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
init  in  1  one-cycle strobe from the controller: load SEED, clear counter and result.
running  in  1  compaction enable; data_in is compacted on every cycle it is high in ARMED/COMPACT.
finish  in  1  one-cycle strobe from the controller: end of test, evaluate.
data_in  in  WIDTH  circuit-under-test response.
signature  out  WIDTH  current MISR contents.
cycle_count  out  CW  number of cycles compacted since the last init.
result_valid  out  1  high from the evaluation cycle until the next init or reset.
pass_fail  out  1  1 = pass; meaningful only while result_valid is high.

Behaviour:
- Reset (async): state=IDLE, signature=SEED, cycle_count=0, result_valid=0, pass_fail=0.
- MISR update: next = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ data_in.
- FSM states: IDLE, ARMED, COMPACT, DONE.
  - IDLE --init--> ARMED.
  - ARMED --running--> COMPACT. The first compaction happens on this same edge.
  - COMPACT: compacts every cycle running=1 and holds when running=0. On finish it evaluates and moves to DONE.
  - DONE: holds all outputs; init --> ARMED.
- init in any state, including mid-COMPACT or DONE: on the next edge signature=SEED, cycle_count=0, result_valid=0, pass_fail=0, state=ARMED. init has priority over finish and running in the same cycle.
- Evaluation on finish in COMPACT or ARMED: the compare uses register values before any same-edge update. Running is ignored on the finish cycle.
  - pass_fail = (signature==GOLDEN) && (cycle_count==EXP_CYCLES).
  - result_valid=1 one cycle after finish; state goes to DONE.
- finish in IDLE (no init seen): abort. result_valid=1, pass_fail=0, state=DONE.
- finish in DONE: ignored.
- running in IDLE or DONE: ignored; signature and count do not change.
- cycle_count saturates at 2^CW-1. It never wraps, so overrun always yields a fail.
- Latency: finish -> result_valid/pass_fail is 1 clock. Verdict is sticky until init or reset.
- Reset asserted mid-COMPACT: immediate return to reset values. No partial verdict is left visible.

Test Plan:
1. Override WIDTH=4, POLY=4'h3, SEED=4'h1, GOLDEN=4'h8, EXP_CYCLES=3. Stimulus: init; running for 3 cycles with data_in=0; finish. Required: signature goes 1->2->4->8, cycle_count=3, result_valid=1 and pass_fail=1 one cycle after finish.
2. Same as 1 but running for 4 cycles. Required: signature=4'h3, cycle_count=4, pass_fail=0, result_valid=1.
3. Same as 1 but data_in=4'h1 on the second cycle. Required: signature after 3 cycles is not 4'h8, so pass_fail=0.
4. finish with no prior init after reset. Required: result_valid=1, pass_fail=0, signature=SEED, cycle_count=0.
5. init and finish asserted together mid-COMPACT. Required: ARMED, signature=SEED, cycle_count=0, result_valid=0. Assert reset mid-run: all outputs return to reset values in the same cycle (async).
6. Default parameters, driven by the real controller with NCLOCK=650 and a correct GOLDEN. Required: cycle_count=651 and pass_fail=1. Verdict stays stable for 100 idle cycles until the next init clears result_valid.
